// File: rtl/rx_engine_if.sv
// Processor/serial-side signal bundle for the UART receive engine.
interface rx_engine_if #(
    parameter int unsigned K_W = 19
);
    logic           RX;
    logic           EIGHT;
    logic           PEN;
    logic           OHEL;
    logic [K_W-1:0] k;
    logic           READS;
    logic [7:0]     UART_DATA;
    logic           RXRDY;
    logic           PERR;
    logic           FERR;
    logic           OVF;

    // Driver side: serial line, frame settings and read strobe
    modport master (
        output RX, EIGHT, PEN, OHEL, k, READS,
        input  UART_DATA, RXRDY, PERR, FERR, OVF
    );

    // Receive engine side
    modport slave (
        input  RX, EIGHT, PEN, OHEL, k, READS,
        output UART_DATA, RXRDY, PERR, FERR, OVF
    );
endinterface

// File: rtl/rx_engine.sv
// UART receive engine: deserialises start/7-8 data/optional parity/stop frames
// sampled at bit centres and presents data plus status to the processor.
module rx_engine #(
    parameter int unsigned K_W = 19
) (
    input  logic        clk,
    input  logic        rst,
    rx_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           rx_meta_q, rx_s_q;
    logic [K_W-1:0] cnt_q, cnt_d;
    logic [K_W-1:0] k_q, k_d;
    logic [3:0]     idx_q, idx_d;
    logic [9:0]     sr_q, sr_d;
    logic           eight_q, eight_d;
    logic           pen_q, pen_d;
    logic           ohel_q, ohel_d;
    logic [7:0]     data_q, data_d;
    logic           rxrdy_q, rxrdy_d;
    logic           perr_q, perr_d;
    logic           ferr_q, ferr_d;
    logic           ovf_q, ovf_d;

    logic [3:0]     n_bits_c;
    logic [9:0]     frame_c;
    logic [7:0]     d_c;
    logic           p_c;
    logic           stop_c;

    // Two-flop synchroniser for the asynchronous serial input; idles high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Justify the shift register into a fixed frame layout and extract fields
    always_comb begin
        n_bits_c = 4'd8 + {3'b000, eight_q} + {3'b000, pen_q};
        frame_c  = '0;
        stop_c   = 1'b0;
        case (n_bits_c)
            4'd10: begin
                frame_c = sr_q;
                stop_c  = frame_c[9];
            end
            4'd9: begin
                frame_c = {1'b1, sr_q[9:1]};
                stop_c  = frame_c[8];
            end
            default: begin
                frame_c = {2'b11, sr_q[9:2]};
                stop_c  = frame_c[7];
            end
        endcase
        d_c = eight_q ? frame_c[7:0] : {1'b0, frame_c[6:0]};
        p_c = eight_q ? frame_c[8]   : frame_c[7];
    end

    // Next-state and next-register logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        eight_d = eight_q;
        pen_d   = pen_q;
        ohel_d  = ohel_q;
        data_d  = data_q;
        rxrdy_d = rxrdy_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovf_d   = ovf_q;

        // A read clears status; a completing frame below takes precedence
        if (bus.READS) begin
            rxrdy_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = '0;
                    k_d     = bus.k;
                    eight_d = bus.EIGHT;
                    pen_d   = bus.PEN;
                    ohel_d  = bus.OHEL;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == (k_q >> 1) - K_W'(1)) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + K_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == k_q - K_W'(1)) begin
                    cnt_d = '0;
                    sr_d  = {rx_s_q, sr_q[9:1]};
                    idx_d = idx_q + 4'd1;
                    if (idx_q + 4'd1 == n_bits_c) begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + K_W'(1);
                end
            end
            DONE: begin
                data_d  = d_c;
                rxrdy_d = 1'b1;
                perr_d  = pen_q & (p_c != (^d_c ^ ohel_q));
                ferr_d  = ~stop_c;
                ovf_d   = rxrdy_q & ~bus.READS;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            eight_q <= 1'b0;
            pen_q   <= 1'b0;
            ohel_q  <= 1'b0;
            data_q  <= '0;
            rxrdy_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            eight_q <= eight_d;
            pen_q   <= pen_d;
            ohel_q  <= ohel_d;
            data_q  <= data_d;
            rxrdy_q <= rxrdy_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.UART_DATA = data_q;
    assign bus.RXRDY     = rxrdy_q;
    assign bus.PERR      = perr_q;
    assign bus.FERR      = ferr_q;
    assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_rx_engine.sv
// Directed bench for rx_engine: frames are driven bit by bit at k=16.
module tb_rx_engine;

    localparam int unsigned K_W = 19;
    localparam int          K   = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rx_engine_if #(.K_W(K_W)) bus ();

    rx_engine #(.K_W(K_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Status packed as {RXRDY, PERR, FERR, OVF} in the low nibble
    function automatic logic [7:0] flags();
        return {4'b0000, bus.RXRDY, bus.PERR, bus.FERR, bus.OVF};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.RX = b;
        repeat (K) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic eight, input logic pen,
                              input logic ohel, input logic par, input logic stop);
        bus.EIGHT = eight;
        bus.PEN   = pen;
        bus.OHEL  = ohel;
        send_bit(1'b0);
        for (int i = 0; i < 7 + int'(eight); i++) send_bit(d[i]);
        if (pen) send_bit(par);
        send_bit(stop);
        bus.RX = 1'b1;
        repeat (K) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reads();
        bus.READS = 1'b1;
        @(posedge clk);
        #1;
        bus.READS = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        bus.RX    = 1'b1;
        bus.EIGHT = 1'b1;
        bus.PEN   = 1'b0;
        bus.OHEL  = 1'b0;
        bus.k     = K_W'(K);
        bus.READS = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data",  bus.UART_DATA, 8'h00);
        chk("reset_flags", flags(),       8'h00);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 8N1 frame
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_data",  bus.UART_DATA, 8'hA5);
        chk("t1_flags", flags(),       8'h08);
        pulse_reads();
        chk("t1_read_clear", flags(), 8'h00);

        // 8E1: 0x3C has four ones, so even parity wants p=0
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t2_bad_data",  bus.UART_DATA, 8'h3C);
        chk("t2_bad_flags", flags(),       8'h0C);
        pulse_reads();
        chk("t2_read_clear", flags(), 8'h00);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_good_flags", flags(), 8'h08);
        pulse_reads();

        // 7O1: 0x41 has two ones, so odd parity wants p=1
        send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t3_good_data",  bus.UART_DATA, 8'h41);
        chk("t3_good_flags", flags(),       8'h08);
        pulse_reads();
        send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t3_bad_data",  bus.UART_DATA, 8'h41);
        chk("t3_bad_flags", flags(),       8'h0C);
        pulse_reads();

        // 7-bit mode forces bit 7 of the data to 0
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_7bit_data", bus.UART_DATA, 8'h7F);
        pulse_reads();

        // Short glitch is a false start; a following frame still decodes
        bus.EIGHT = 1'b1;
        bus.PEN   = 1'b0;
        bus.RX    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.RX = 1'b1;
        repeat (3 * K) @(posedge clk);
        #1;
        chk("t4_glitch_flags", flags(),       8'h00);
        chk("t4_glitch_data",  bus.UART_DATA, 8'h7F);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_after_data",  bus.UART_DATA, 8'h5A);
        chk("t4_after_flags", flags(),       8'h08);
        pulse_reads();

        // Framing error, then overrun, then read clears everything
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_ferr_data",  bus.UART_DATA, 8'h55);
        chk("t5_ferr_flags", flags(),       8'h0A);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_ovf_data",  bus.UART_DATA, 8'h12);
        chk("t5_ovf_flags", flags(),       8'h09);
        pulse_reads();
        chk("t5_read_flags", flags(),       8'h00);
        chk("t5_read_data",  bus.UART_DATA, 8'h12);

        // Reset in the middle of the data bits
        send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_pre_flags", flags(), 8'h08);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_data",  bus.UART_DATA, 8'h00);
        chk("t6_rst_flags", flags(),       8'h00);
        bus.RX = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_after_data",  bus.UART_DATA, 8'h81);
        chk("t6_after_flags", flags(),       8'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
